// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller arbitrating instruction fetch and
// data load/store onto a single 8-bit RAM port with one-cycle read latency.
// Ports: clk, rst (async active-low); fetch side inst_fe/inst_fpc ->
// inst/inst_pc/inst_ok; data side mem_re/mem_we/mem_addr/mem_width/
// mem_wdata -> mem_rdata/mem_ok; RAM side ram_din -> ram_dout/ram_a/ram_wr.
module mem_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_fe,
   input  logic [31:0] inst_fpc,
   output logic [31:0] inst,
   output logic        inst_ok,
   output logic [31:0] inst_pc,
   input  logic        mem_re,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [1:0]  mem_width,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_ok,
   input  logic [7:0]  ram_din,
   output logic [7:0]  ram_dout,
   output logic [31:0] ram_a,
   output logic        ram_wr
);

   typedef enum logic [2:0] {
      IDLE,
      IFETCH,
      DREAD,
      DWRITE,
      RESP
   } state_t;

   state_t      state;
   logic [2:0]  cnt;
   logic [2:0]  nbytes;
   logic [31:0] base;
   logic [31:0] wdat;
   logic [31:0] rbuf;
   logic [31:0] rbuf_nxt;
   logic [1:0]  cidx;

   function automatic logic [2:0] wlen(input logic [1:0] w);
      case (w)
         2'b00:   wlen = 3'd1;
         2'b01:   wlen = 3'd2;
         default: wlen = 3'd4;
      endcase
   endfunction

   // cnt is the edge index since accept; the byte captured at edge k
   // was issued at edge k-2.
   assign cidx = cnt[1:0] - 2'd2;

   always_comb begin
      rbuf_nxt = rbuf;
      rbuf_nxt[{cidx, 3'b000} +: 8] = ram_din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= 3'd0;
         nbytes    <= 3'd0;
         base      <= 32'd0;
         wdat      <= 32'd0;
         rbuf      <= 32'd0;
         inst      <= 32'd0;
         inst_pc   <= 32'd0;
         inst_ok   <= 1'b0;
         mem_rdata <= 32'd0;
         mem_ok    <= 1'b0;
         ram_a     <= 32'd0;
         ram_dout  <= 8'd0;
         ram_wr    <= 1'b0;
      end else begin
         inst_ok <= 1'b0;
         mem_ok  <= 1'b0;
         unique case (state)
            IDLE: begin
               cnt  <= 3'd1;
               rbuf <= 32'd0;
               if (mem_we) begin
                  state    <= DWRITE;
                  base     <= mem_addr;
                  nbytes   <= wlen(mem_width);
                  wdat     <= mem_wdata;
                  ram_wr   <= 1'b1;
                  ram_a    <= mem_addr;
                  ram_dout <= mem_wdata[7:0];
               end else if (mem_re) begin
                  state  <= DREAD;
                  base   <= mem_addr;
                  nbytes <= wlen(mem_width);
                  ram_a  <= mem_addr;
               end else if (inst_fe) begin
                  state  <= IFETCH;
                  base   <= inst_fpc;
                  nbytes <= 3'd4;
                  ram_a  <= inst_fpc;
               end
            end
            IFETCH, DREAD: begin
               cnt <= cnt + 3'd1;
               if (cnt < nbytes)
                  ram_a <= base + {29'd0, cnt};
               if (cnt >= 3'd2)
                  rbuf <= rbuf_nxt;
               if (cnt == nbytes + 3'd1) begin
                  state <= RESP;
                  ram_a <= 32'd0;
                  if (state == IFETCH) begin
                     inst    <= rbuf_nxt;
                     inst_pc <= base;
                     inst_ok <= 1'b1;
                  end else begin
                     mem_rdata <= rbuf_nxt;
                     mem_ok    <= 1'b1;
                  end
               end
            end
            DWRITE: begin
               if (cnt < nbytes) begin
                  cnt      <= cnt + 3'd1;
                  ram_a    <= base + {29'd0, cnt};
                  ram_dout <= wdat[{cnt[1:0], 3'b000} +: 8];
               end else begin
                  state    <= RESP;
                  ram_wr   <= 1'b0;
                  ram_dout <= 8'd0;
                  ram_a    <= 32'd0;
                  mem_ok   <= 1'b1;
               end
            end
            RESP: begin
               state <= IDLE;
               cnt   <= 3'd0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized bench for mem_ctrl with a byte-RAM device and a
// transaction-level reference model checked every cycle.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_fe;
   logic [31:0] inst_fpc;
   logic [31:0] inst;
   logic        inst_ok;
   logic [31:0] inst_pc;
   logic        mem_re;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [1:0]  mem_width;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ok;
   logic [7:0]  ram_din = 8'd0;
   logic [7:0]  ram_dout;
   logic [31:0] ram_a;
   logic        ram_wr;

   mem_ctrl dut (
      .clk(clk), .rst(rst),
      .inst_fe(inst_fe), .inst_fpc(inst_fpc),
      .inst(inst), .inst_ok(inst_ok), .inst_pc(inst_pc),
      .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_width(mem_width), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ok(mem_ok),
      .ram_din(ram_din), .ram_dout(ram_dout),
      .ram_a(ram_a), .ram_wr(ram_wr)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   function automatic logic [7:0] dflt(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
   endfunction

   // RAM device
   logic [7:0] dev_mem [logic [31:0]];
   function automatic logic [7:0] dev_rd(input logic [31:0] a);
      return dev_mem.exists(a) ? dev_mem[a] : dflt(a);
   endfunction
   always @(posedge clk) begin
      if (ram_wr) dev_mem[ram_a] = ram_dout;
      ram_din <= dev_rd(ram_a);
   end

   // reference model state
   logic [7:0] ref_mem [logic [31:0]];
   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   typedef struct {
      int          kind;
      int unsigned cyc;
      logic [31:0] data;
      logic [31:0] pc;
   } exp_t;
   exp_t q[$];
   logic [31:0] m_inst = 0, m_pc = 0, m_rdata = 0;
   int unsigned last_iok = 0, last_mok = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h cyc=%0d", nm, act, exp, cyc);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s cyc=%0d", nm, cyc);
   endtask

   // per-cycle compare against the model
   always @(negedge clk) begin : cmp
      exp_t e;
      if (rst) begin
         if (inst_ok && mem_ok) fail("both_ok");
         if (!ram_wr) chk("dout_idle", {24'd0, ram_dout}, 32'd0);
         if (inst_ok || mem_ok) begin
            if (inst_ok) last_iok = cyc;
            if (mem_ok) last_mok = cyc;
            if (q.size() == 0) begin
               fail("spurious_ok");
            end else begin
               e = q.pop_front();
               chk("ok_cyc", cyc, e.cyc);
               chk("ok_kind", {31'd0, inst_ok}, (e.kind == 0) ? 1 : 0);
               if (e.kind == 0) begin
                  m_inst = e.data;
                  m_pc   = e.pc;
               end else if (e.kind == 1) begin
                  m_rdata = e.data;
               end
            end
         end else if (q.size() != 0 && q[0].cyc <= cyc) begin
            fail("missing_ok");
            void'(q.pop_front());
         end
         chk("inst", inst, m_inst);
         chk("inst_pc", inst_pc, m_pc);
         chk("mem_rdata", mem_rdata, m_rdata);
      end
   end

   task automatic preload(input logic [31:0] a, input logic [7:0] b);
      dev_mem[a] = b;
      ref_mem[a] = b;
   endtask

   task automatic wait_cyc(input int unsigned n);
      int g = 0;
      while (cyc < n && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (cyc < n) fail("timeout");
   endtask

   task automatic drop();
      inst_fe = 1'b0;
      mem_re  = 1'b0;
      mem_we  = 1'b0;
   endtask

   task automatic scramble();
      inst_fpc  = $urandom;
      mem_addr  = $urandom;
      mem_wdata = $urandom;
      mem_width = 2'($urandom_range(0, 3));
   endtask

   // drive a request at this negedge (controller idle) and predict result
   task automatic start(input bit fe, input bit re, input bit we,
                        input logic [31:0] fpc, input logic [31:0] addr,
                        input logic [1:0] w, input logic [31:0] wd,
                        output int unsigned e0, output int unsigned done);
      exp_t e;
      int n;
      inst_fe = fe; mem_re = re; mem_we = we;
      inst_fpc = fpc; mem_addr = addr; mem_width = w; mem_wdata = wd;
      e0 = cyc + 1;
      n = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
      e.data = 0;
      e.pc = 0;
      if (we) begin
         for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = wd[8*i +: 8];
         done = e0 + n;
         e.kind = 2;
      end else if (re) begin
         for (int i = 0; i < n; i++) e.data[8*i +: 8] = ref_rd(addr + 32'(i));
         done = e0 + n + 1;
         e.kind = 1;
      end else begin
         for (int i = 0; i < 4; i++) e.data[8*i +: 8] = ref_rd(fpc + 32'(i));
         e.pc = fpc;
         done = e0 + 5;
         e.kind = 0;
      end
      e.cyc = done;
      q.push_back(e);
   endtask

   int unsigned e0, dn, e0b, dnb;
   logic [31:0] a, wd;
   bit hold;
   int sel;

   initial begin
      rst = 1'b0;
      drop();
      inst_fpc = 0; mem_addr = 0; mem_width = 0; mem_wdata = 0;
      #1;
      chk("rst_inst", inst, 0);
      chk("rst_inst_pc", inst_pc, 0);
      chk("rst_inst_ok", {31'd0, inst_ok}, 0);
      chk("rst_rdata", mem_rdata, 0);
      chk("rst_mem_ok", {31'd0, mem_ok}, 0);
      chk("rst_ram_a", ram_a, 0);
      chk("rst_ram_dout", {24'd0, ram_dout}, 0);
      chk("rst_ram_wr", {31'd0, ram_wr}, 0);
      @(negedge clk);
      rst = 1'b1;

      // fetch
      preload(32'h100, 8'h13); preload(32'h101, 8'h05);
      preload(32'h102, 8'h10); preload(32'h103, 8'h00);
      start(1, 0, 0, 32'h100, 0, 0, 0, e0, dn);
      wait_cyc(e0); drop();
      wait_cyc(dn + 1);
      chk("fetch_inst", inst, 32'h00100513);
      chk("fetch_pc", inst_pc, 32'h100);
      chk("fetch_lat", last_iok - e0, 5);

      // contention: read wins, fetch held and taken after RESP
      preload(32'h20, 8'hAB);
      start(1, 1, 0, 32'h100, 32'h20, 2'd0, 0, e0, dn);
      wait_cyc(e0); mem_re = 1'b0;
      wait_cyc(dn + 1);
      start(1, 0, 0, 32'h100, 32'h20, 2'd0, 0, e0b, dnb);
      wait_cyc(e0b); drop();
      wait_cyc(dnb + 1);
      chk("cont_rdata", mem_rdata, 32'h000000AB);
      chk("cont_rd_lat", last_mok - e0, 2);
      chk("cont_fe_lat", last_iok - e0, 9);

      // store
      start(0, 0, 1, 0, 32'h40, 2'd2, 32'hDEADBEEF, e0, dn);
      wait_cyc(e0); drop();
      wait_cyc(dn + 1);
      chk("st_b0", {24'd0, dev_rd(32'h40)}, 32'hEF);
      chk("st_b1", {24'd0, dev_rd(32'h41)}, 32'hBE);
      chk("st_b2", {24'd0, dev_rd(32'h42)}, 32'hAD);
      chk("st_b3", {24'd0, dev_rd(32'h43)}, 32'hDE);
      chk("st_lat", last_mok - e0, 4);
      chk("st_wr_off", {31'd0, ram_wr}, 0);

      // wrap
      preload(32'hFFFFFFFF, 8'h34); preload(32'h0, 8'h12);
      start(0, 1, 0, 0, 32'hFFFFFFFF, 2'd1, 0, e0, dn);
      wait_cyc(e0); drop();
      chk("wrap_a0", ram_a, 32'hFFFFFFFF);
      wait_cyc(e0 + 1);
      chk("wrap_a1", ram_a, 32'h0);
      wait_cyc(dn + 1);
      chk("wrap_rdata", mem_rdata, 32'h00001234);

      // redirect mid-fetch
      preload(32'h200, 8'h11); preload(32'h201, 8'h22);
      preload(32'h202, 8'h33); preload(32'h203, 8'h44);
      start(1, 0, 0, 32'h100, 0, 0, 0, e0, dn);
      wait_cyc(e0 + 1); inst_fpc = 32'h200;
      wait_cyc(dn + 1);
      chk("redir_pc", inst_pc, 32'h100);
      chk("redir_inst", inst, 32'h00100513);
      start(1, 0, 0, 32'h200, 0, 0, 0, e0, dn);
      wait_cyc(e0); drop();
      wait_cyc(dn + 1);
      chk("redir2_inst", inst, 32'h44332211);
      chk("redir2_pc", inst_pc, 32'h200);

      // randomized traffic
      for (int t = 0; t < 60; t++) begin
         sel  = $urandom_range(1, 7);
         hold = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 3) == 0) ?
              32'hFFFFFFFC + 32'($urandom_range(0, 7)) :
              32'h1000 + 32'($urandom_range(0, 63));
         wd = $urandom;
         start(sel[0], sel[1], sel[2],
               32'h1000 + 32'($urandom_range(0, 63)), a,
               2'($urandom_range(0, 3)), wd, e0, dn);
         wait_cyc(e0);
         if (!hold) drop();
         for (int g = 0; g < 20 && cyc < dn + 1; g++) begin
            scramble();
            @(negedge clk);
         end
         wait_cyc(dn + 1);
         drop();
         chk("q_drained", q.size(), 0);
         if (sel[2])
            for (int i = -1; i < 5; i++)
               chk("dev_mem", {24'd0, dev_rd(a + 32'(i))},
                   {24'd0, ref_rd(a + 32'(i))});
      end

      // async reset mid-store after two bytes
      start(0, 0, 0, 32'h0, 0, 0, 0, e0, dn);
      void'(q.pop_back());
      inst_fe = 1'b0;
      mem_we = 1'b1; mem_addr = 32'h80; mem_width = 2'd2;
      mem_wdata = 32'hCAFEF00D;
      e0 = cyc + 1;
      wait_cyc(e0); drop();
      wait_cyc(e0 + 2);
      #2;
      rst = 1'b0;
      q.delete();
      m_inst = 0; m_pc = 0; m_rdata = 0;
      ref_mem[32'h80] = 8'h0D;
      ref_mem[32'h81] = 8'hF0;
      #1;
      chk("ar_inst", inst, 0);
      chk("ar_pc", inst_pc, 0);
      chk("ar_rdata", mem_rdata, 0);
      chk("ar_mem_ok", {31'd0, mem_ok}, 0);
      chk("ar_ram_a", ram_a, 0);
      chk("ar_wr", {31'd0, ram_wr}, 0);
      chk("ar_dout", {24'd0, ram_dout}, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++)
         chk("ar_mem", {24'd0, dev_rd(32'h80 + 32'(i))},
             {24'd0, ref_rd(32'h80 + 32'(i))});
      chk("ar_b2", {24'd0, dev_rd(32'h82)}, {24'd0, dflt(32'h82)});
      start(0, 1, 0, 0, 32'h80, 2'd2, 0, e0, dn);
      wait_cyc(e0); drop();
      wait_cyc(dn + 1);
      chk("ar_rd_lat", last_mok - e0, 5);
      chk("ar_rd_lo", {16'd0, mem_rdata[15:0]}, 32'hF00D);

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset; 0 forces the reset state immediately, independent of clk.
REQ-003 inst_fe  in  1  instruction fetch request, level, from the fetch stage.
REQ-004 inst_fpc  in  32  instruction fetch address.
REQ-005 inst  out  32  fetched instruction word, little-endian.
REQ-006 inst_ok  out  1  one-cycle pulse: inst/inst_pc valid.
REQ-007 inst_pc  out  32  address of the word in inst.
REQ-008 mem_re  in  1  data read request, level.
REQ-009 mem_we  in  1  data write request, level.
REQ-010 mem_addr  in  32  data byte address.
REQ-011 mem_width  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-012 mem_wdata  in  32  store data; low bytes used per width.
REQ-013 mem_rdata  out  32  load data, zero-extended.
REQ-014 mem_ok  out  1  one-cycle pulse: data access complete.
REQ-015 ram_din  in  8  RAM read byte; valid one cycle after the address was sampled by the RAM.
REQ-016 ram_dout  out  8  RAM write byte.
REQ-017 ram_a  out  32  RAM byte address.
REQ-018 ram_wr  out  1  1 = write, 0 = read.

Function
REQ-019 All RAM-side outputs, inst, inst_pc, inst_ok, mem_rdata and mem_ok SHALL be registered.
REQ-020 State machine: IDLE, IFETCH, DREAD, DWRITE, RESP; a 3-bit byte counter counts bytes issued or captured.
REQ-021 IDLE: on a rising edge with mem_we=1 -> DWRITE; else mem_re=1 -> DREAD; else inst_fe=1 -> IFETCH; else remain in IDLE. Data access has priority over fetch; write has priority over read.
REQ-022 On acceptance, base address, width and wdata SHALL be latched; later request changes (including inst_fe dropping or inst_fpc changing) SHALL NOT affect the transfer in flight.
REQ-023 Reads: byte i address = base+i, driven on the accept edge plus i; the byte is captured from ram_din two edges after it is driven; byte i lands in bits [8i+7:8i].
REQ-024 IFETCH always transfers 4 bytes; DREAD transfers 1/2/4 bytes per width.
REQ-025 Read latency: with accept at edge E0 and N bytes, the last byte is captured at E(N+1), and inst_ok/mem_ok SHALL be high for exactly the cycle after E(N+1) (word: after E5; byte: after E2).
REQ-026 Writes: ram_wr=1, ram_a=base+i and ram_dout=wdata[8i+7:8i] driven at edge E0+i for i=0..N-1; at E(N) ram_wr=0 and mem_ok rises for one cycle.
REQ-027 Address arithmetic SHALL be 32-bit modulo; 0xFFFFFFFF+1 wraps to 0x00000000.
REQ-028 Upon completion, the FSM SHALL enter RESP for exactly one cycle with the ok pulse high, then return to IDLE; no request is sampled during RESP, so a still-asserted level request is not re-accepted early.
REQ-029 inst_pc SHALL equal the latched fetch base; inst/inst_pc hold until the next fetch completion; mem_rdata holds until the next read completion.
REQ-030 Outside write cycles, ram_wr=0 and ram_dout=0; in IDLE, ram_a=0.
REQ-031 Never assert inst_ok and mem_ok in the same cycle.

Reset
REQ-032 While rst=0: state IDLE, counter 0, all outputs 0 (inst, inst_pc, inst_ok, mem_rdata, mem_ok, ram_a, ram_dout, ram_wr).
REQ-033 Reset mid-transfer SHALL abort it with no ok pulse and no further RAM write; after rst releases, the first rising edge samples requests in IDLE.

Verification
REQ-034 Fetch: RAM[0x100..0x103]=13,05,10,00; inst_fe=1, inst_fpc=0x100 -> inst_ok one cycle after E5, inst=0x00100513, inst_pc=0x100.
REQ-035 Contention: inst_fe=1 and mem_re=1 (byte, addr 0x20, RAM=0xAB) at the same edge -> mem_ok after E2, mem_rdata=0x000000AB; the fetch is accepted the edge after RESP.
REQ-036 Store: mem_we=1, word, addr 0x40, wdata=0xDEADBEEF -> RAM writes EF,BE,AD,DE at 0x40..0x43, mem_ok after E4; ram_wr=0 afterwards.
REQ-037 Wrap: half read at 0xFFFFFFFF -> ram_a sequence 0xFFFFFFFF, 0x00000000; mem_rdata={RAM[0],RAM[0xFFFFFFFF]} zero-extended.
REQ-038 Redirect: inst_fpc changes from 0x100 to 0x200 at E2 of a fetch -> inst_pc=0x100, inst from 0x100; the 0x200 fetch starts after RESP.
REQ-039 Async reset: rst=0 asserted mid-word-store after 2 bytes -> outputs 0 immediately, no mem_ok, RAM bytes 2-3 unchanged.
